// File: rtl/carrier_detector.sv
// carrier_detector: drives the ADC sample clock, captures 8-bit samples and
// measures the incoming carrier's period (in samples) and peak-to-peak
// amplitude using hysteretic rising-crossing detection around MID.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   clk_AD      ADC sample clock (low for CLK_DIV/2 cycles, then high)
//   datain      ADC sample, captured on the last low cycle of clk_AD
//   measure_en  level-sensitive measurement enable
//   period      last measured period, in samples
//   amp_pp      last measured max-min over one period
//   valid       one-cycle pulse when period/amp_pp update
//   lock        two consecutive periods agree within +/-1
//   no_carrier  sticky timeout flag, cleared by the next valid
module carrier_detector #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned MID     = 128,
  parameter int unsigned HYST    = 8,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  output logic        clk_AD,
  input  logic [7:0]  datain,
  input  logic        measure_en,
  output logic [15:0] period,
  output logic [7:0]  amp_pp,
  output logic        valid,
  output logic        lock,
  output logic        no_carrier
);

  localparam int unsigned HALF = CLK_DIV / 2;
  localparam int unsigned CW   = $clog2(CLK_DIV);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_STB  = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [8:0]    HI_TH    = 9'(MID + HYST);
  localparam logic [8:0]    LO_TH    = 9'(MID - HYST);
  localparam logic [15:0]   TO       = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    SEEK,
    MEASURE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic [15:0]   smp_cnt_q, smp_cnt_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    max_q, max_d;
  logic          have_prev_q, have_prev_d;
  logic [15:0]   period_q, period_d;
  logic [7:0]    amp_q, amp_d;
  logic          valid_q, valid_d;
  logic          lock_q, lock_d;
  logic          nc_q, nc_d;

  logic          strobe;
  logic          rise;
  logic          fall;
  logic [8:0]    samp9;
  logic [15:0]   smp_inc;
  logic [15:0]   pdiff;

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    smp_cnt_d   = smp_cnt_q;
    min_d       = min_q;
    max_d       = max_q;
    have_prev_d = have_prev_q;
    period_d    = period_q;
    amp_d       = amp_q;
    valid_d     = 1'b0;
    lock_d      = lock_q;
    nc_d        = nc_q;

    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    strobe  = (cnt_q == CNT_STB);
    samp9   = {1'b0, datain};
    rise    = strobe && !level_q && (samp9 >= HI_TH);
    fall    = strobe &&  level_q && (samp9 <= LO_TH);
    smp_inc = smp_cnt_q + 16'd1;
    pdiff   = (smp_cnt_q >= period_q) ? (smp_cnt_q - period_q)
                                      : (period_q - smp_cnt_q);

    if (rise) begin
      level_d = 1'b1;
    end else if (fall) begin
      level_d = 1'b0;
    end

    // Dropping measure_en overrides any event on the same cycle,
    // including a closing crossing.
    if (!measure_en) begin
      state_d     = IDLE;
      lock_d      = 1'b0;
      have_prev_d = 1'b0;
      smp_cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SEEK;
        end
        SEEK: begin
          if (strobe) begin
            if (rise) begin
              smp_cnt_d = 16'd1;
              min_d     = datain;
              max_d     = datain;
              state_d   = MEASURE;
            end else if (smp_inc == TO) begin
              nc_d      = 1'b1;
              smp_cnt_d = '0;
            end else begin
              smp_cnt_d = smp_inc;
            end
          end
        end
        MEASURE: begin
          if (strobe) begin
            // Crossing is checked before timeout so it wins a tie;
            // the closing sample is excluded from min/max and seeds
            // the next window as its sample 1.
            if (rise) begin
              period_d    = smp_cnt_q;
              amp_d       = max_q - min_q;
              valid_d     = 1'b1;
              nc_d        = 1'b0;
              lock_d      = have_prev_q && (pdiff <= 16'd1);
              have_prev_d = 1'b1;
              smp_cnt_d   = 16'd1;
              min_d       = datain;
              max_d       = datain;
            end else begin
              if (datain < min_q) min_d = datain;
              if (datain > max_q) max_d = datain;
              if (smp_inc == TO) begin
                nc_d        = 1'b1;
                lock_d      = 1'b0;
                have_prev_d = 1'b0;
                smp_cnt_d   = '0;
                state_d     = SEEK;
              end else begin
                smp_cnt_d = smp_inc;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      smp_cnt_q   <= '0;
      min_q       <= '0;
      max_q       <= '0;
      have_prev_q <= 1'b0;
      period_q    <= '0;
      amp_q       <= '0;
      valid_q     <= 1'b0;
      lock_q      <= 1'b0;
      nc_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      smp_cnt_q   <= smp_cnt_d;
      min_q       <= min_d;
      max_q       <= max_d;
      have_prev_q <= have_prev_d;
      period_q    <= period_d;
      amp_q       <= amp_d;
      valid_q     <= valid_d;
      lock_q      <= lock_d;
      nc_q        <= nc_d;
    end
  end

  assign clk_AD     = (cnt_q >= CNT_HALF);
  assign period     = period_q;
  assign amp_pp     = amp_q;
  assign valid      = valid_q;
  assign lock       = lock_q;
  assign no_carrier = nc_q;

endmodule

// File: tb/tb_carrier_detector.sv
// Testbench for carrier_detector: drives one ADC sample per strobe, pushes
// the expected measurement for each closing crossing into a queue and
// compares against every valid pulse the DUT produces.
module tb_carrier_detector;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned HALF    = CLK_DIV / 2;
  localparam int unsigned TIMEOUT = 1023;

  logic        clk;
  logic        reset;
  logic        clk_AD;
  logic [7:0]  datain;
  logic        measure_en;
  logic [15:0] period;
  logic [7:0]  amp_pp;
  logic        valid;
  logic        lock;
  logic        no_carrier;

  carrier_detector #(
    .CLK_DIV (CLK_DIV),
    .MID     (128),
    .HYST    (8),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_AD     (clk_AD),
    .datain     (datain),
    .measure_en (measure_en),
    .period     (period),
    .amp_pp     (amp_pp),
    .valid      (valid),
    .lock       (lock),
    .no_carrier (no_carrier)
  );

  typedef struct {
    int unsigned samp;
    logic [15:0] per;
    logic [7:0]  amp;
    logic        lk;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned n_samp   = 0;
  int unsigned tb_cnt;
  logic [7:0]  sine_tbl [32];
  int unsigned sine_amp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent model of the divider phase.
  always @(posedge clk or posedge reset) begin
    if (reset) tb_cnt <= 0;
    else       tb_cnt <= (tb_cnt == CLK_DIV - 1) ? 0 : tb_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one sample for the next strobe and return #1 after that strobe edge.
  task automatic send(input logic [7:0] v);
    datain = v;
    while (tb_cnt != HALF - 1) @(negedge clk);
    @(posedge clk);
    #1;
    n_samp++;
  endtask

  task automatic window(input int unsigned hi, input int unsigned lo);
    for (int unsigned i = 0; i < hi; i++) send(8'd200);
    for (int unsigned i = 0; i < lo; i++) send(8'd50);
  endtask

  // The next sample sent is the closing crossing of a window.
  task automatic expect_valid(input int unsigned per, input int unsigned amp, input logic lk);
    exp_t e;
    e.samp = n_samp + 1;
    e.per  = 16'(per);
    e.amp  = 8'(amp);
    e.lk   = lk;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    repeat (2) @(negedge clk);
    #1;
    check_eq(tag, 32'(exp_q.size()), 0);
  endtask

  task automatic go_idle();
    measure_en = 1'b0;
    repeat (4) send(8'd0);
    measure_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", 32'(exp_q.size()), 1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("valid_sample", n_samp, e.samp);
        check_eq("valid_phase", tb_cnt, HALF);
        check_eq("period", {16'd0, period}, {16'd0, e.per});
        check_eq("amp_pp", {24'd0, amp_pp}, {24'd0, e.amp});
        check_eq("lock", {31'd0, lock}, {31'd0, e.lk});
        check_eq("no_carrier_at_valid", {31'd0, no_carrier}, 0);
      end
    end
  end

  initial begin
    sine_tbl = '{8'd128, 8'd148, 8'd166, 8'd184, 8'd199, 8'd211, 8'd220, 8'd226,
                 8'd228, 8'd226, 8'd220, 8'd211, 8'd199, 8'd184, 8'd166, 8'd148,
                 8'd128, 8'd108, 8'd90,  8'd72,  8'd57,  8'd45,  8'd36,  8'd30,
                 8'd28,  8'd30,  8'd36,  8'd45,  8'd57,  8'd72,  8'd90,  8'd108};
    begin
      int unsigned mx, mn;
      mx = 0;
      mn = 255;
      for (int i = 0; i < 32; i++) begin
        if (sine_tbl[i] > mx) mx = sine_tbl[i];
        if (sine_tbl[i] < mn) mn = sine_tbl[i];
      end
      sine_amp = mx - mn;
    end

    reset      = 1'b1;
    datain     = 8'd0;
    measure_en = 1'b0;

    // Reset values and divider phase.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_clk_AD", {31'd0, clk_AD}, 0);
    check_eq("rst_period", {16'd0, period}, 0);
    check_eq("rst_amp", {24'd0, amp_pp}, 0);
    check_eq("rst_valid", {31'd0, valid}, 0);
    check_eq("rst_lock", {31'd0, lock}, 0);
    check_eq("rst_no_carrier", {31'd0, no_carrier}, 0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("clk_AD_phase", {31'd0, clk_AD}, ((i % 4) >= 2) ? 1 : 0);
    end

    // Square wave, 32-sample period.
    go_idle();
    window(16, 16); expect_valid(32, 150, 1'b0);
    window(16, 16); expect_valid(32, 150, 1'b1);
    window(16, 16); expect_valid(32, 150, 1'b1);
    send(8'd200);
    drain("square_done");

    // Lock gain/loss including the +/-1 boundary.
    go_idle();
    window(16, 16); expect_valid(32, 150, 1'b0);
    window(16, 16); expect_valid(32, 150, 1'b1);
    window(20, 20); expect_valid(40, 150, 1'b0);
    window(21, 20); expect_valid(41, 150, 1'b1);
    window(22, 21); expect_valid(43, 150, 1'b0);
    send(8'd200);
    drain("lock_done");

    // Minimum period of 2 samples.
    go_idle();
    window(1, 1); expect_valid(2, 150, 1'b0);
    window(1, 1); expect_valid(2, 150, 1'b1);
    send(8'd200);
    drain("minper_done");

    // Loopback sine table.
    go_idle();
    for (int i = 0; i < 130; i++) begin
      if (i >= 32 && (i % 32) == 1) expect_valid(32, sine_amp, (i >= 64));
      send(sine_tbl[i % 32]);
    end
    drain("sine_done");

    // Abort mid-window, including a crossing while disabled.
    go_idle();
    window(16, 16); expect_valid(32, 150, 1'b0);
    window(16, 16); expect_valid(32, 150, 1'b1);
    send(8'd200);
    repeat (15) send(8'd200);
    repeat (16) send(8'd50);
    measure_en = 1'b0;
    send(8'd200);
    check_eq("abort_lock", {31'd0, lock}, 0);
    repeat (9) send(8'd200);
    drain("abort_gap");
    measure_en = 1'b1;
    repeat (6) send(8'd200);
    repeat (16) send(8'd50);
    window(16, 16); expect_valid(32, 150, 1'b0);
    send(8'd200);
    drain("abort_done");

    // Timeout inside MEASURE while locked.
    go_idle();
    window(16, 16); expect_valid(32, 150, 1'b0);
    window(16, 16); expect_valid(32, 150, 1'b1);
    send(8'd200);
    repeat (TIMEOUT - 2) send(8'd200);
    check_eq("mto_nc_before", {31'd0, no_carrier}, 0);
    check_eq("mto_lock_before", {31'd0, lock}, 1);
    send(8'd200);
    check_eq("mto_nc", {31'd0, no_carrier}, 1);
    check_eq("mto_lock", {31'd0, lock}, 0);
    repeat (16) send(8'd50);
    check_eq("mto_nc_sticky", {31'd0, no_carrier}, 1);
    window(16, 16); expect_valid(32, 150, 1'b0);
    send(8'd200);
    drain("mto_done");

    // Hysteresis: samples inside the band never cross; SEEK times out.
    go_idle();
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) send((i % 2) == 0 ? 8'd130 : 8'd126);
    check_eq("hyst_nc_before", {31'd0, no_carrier}, 0);
    send(8'd126);
    check_eq("hyst_nc", {31'd0, no_carrier}, 1);
    drain("hyst_done");

    // Crossing on the strobe where the counter hits TIMEOUT: crossing wins.
    window(511, 511); expect_valid(TIMEOUT - 1, 150, 1'b0);
    send(8'd200);
    check_eq("tie_nc", {31'd0, no_carrier}, 0);
    drain("tie_done");

    // Reset mid-window: everything back to reset values at once.
    repeat (5) send(8'd200);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_period", {16'd0, period}, 0);
    check_eq("mid_rst_amp", {24'd0, amp_pp}, 0);
    check_eq("mid_rst_valid", {31'd0, valid}, 0);
    check_eq("mid_rst_lock", {31'd0, lock}, 0);
    check_eq("mid_rst_clk_AD", {31'd0, clk_AD}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) send(8'd200);
    drain("final_queue");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/carrier_detector.md
# carrier_detector

Receive-side counterpart of the carrier generator path: drives the sampling clock of an 8-bit ADC, captures its samples, and measures the incoming carrier's period (in samples) and peak-to-peak amplitude. It uses hysteretic rising-crossing detection around a programmable mid-level. It sits between the ADC pins and the measurement and control logic, and closes the loopback DAC→ADC for self-test.

## Interface
- CLK_DIV, 4: clk cycles per ADC sample; even, ≥2
- MID, 128: crossing threshold centre (unsigned 8-bit)
- HYST, 8: hysteresis half-width; MID±HYST must lie in 0..255
- TIMEOUT, 1023: samples without a rising crossing before declaring no carrier; ≤65535

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clk_AD  out  1  ADC sample clock
- datain  in  8  ADC sample, unsigned, stable while clk_AD low
- measure_en  in  1  enables measurement; level-sensitive
- period  out  16  last measured period, in samples
- amp_pp  out  8  last measured max−min over one period
- valid  out  1  one-cycle pulse when period/amp_pp update
- lock  out  1  two consecutive periods agree within ±1
- no_carrier  out  1  sticky timeout flag; cleared by the next valid

## Operation
- **Divider and sample strobe**
  - Divider cnt runs 0..CLK_DIV−1 continuously, independent of measure_en.
  - clk_AD = 1 when cnt ≥ CLK_DIV/2.
  - Sample strobe: cycle where cnt == CLK_DIV/2−1 (last low cycle). datain is registered on that cycle.
- **Hysteresis level** (tracked on every strobe, all states)
  - Level goes LOW→HIGH when sample ≥ MID+HYST.
  - Level goes HIGH→LOW when sample ≤ MID−HYST.
  - Otherwise the level holds.
  - Rising crossing = LOW→HIGH transition. Comparisons are unsigned with 9-bit intermediate.
  - Level resets to LOW.
- **FSM**
  - IDLE:
    - Entered on reset or whenever measure_en = 0; takes priority over any event.
    - lock cleared; period and amp_pp hold.
    - Go to SEEK when measure_en = 1.
  - SEEK:
    - Wait for a rising crossing, then open a window and go to MEASURE.
    - The sample counter increments per strobe. If it reaches TIMEOUT, set no_carrier, clear the counter, and stay in SEEK.
  - MEASURE, on each strobe:
    - Update window min/max and increment the counter.
    - On a rising crossing: period ← samples in window, amp_pp ← max−min, pulse valid, clear no_carrier, open a new window.
    - If the counter reaches TIMEOUT: set no_carrier, clear lock, go to SEEK.
- **Window rules**
  - A window contains the opening crossing sample (inclusive) up to the closing crossing sample (exclusive).
  - The closing sample seeds min/max and counts as sample 1 of the next window.
  - period is the window sample count, 16-bit, never 0.
- **Lock**
  - Set on a valid whose period differs from the previous valid's period by ≤1.
  - Cleared on a valid differing by >1, on timeout, or in IDLE.
  - The first valid after SEEK never sets lock.

## Timing
- Reset values: clk_AD 0, cnt 0, period 0, amp_pp 0, valid 0, lock 0, no_carrier 0, FSM IDLE.
- valid, period, amp_pp and lock update in the cycle after the strobe of the closing crossing sample. Latency is 1 clk.
- no_carrier asserts in the cycle after the timeout strobe.
- Timeout and crossing on the same strobe: the crossing wins. Measure normally; no timeout.
- measure_en falling on a crossing strobe: no valid; enter IDLE.
- Reset asserted mid-window: all state returns to reset values immediately. No partial result is output.
- Minimum detectable period is 2 samples; maximum is TIMEOUT−1.

## Test plan
- **Reset/divider.** Assert reset for 3 cycles, release with CLK_DIV=4 → all outputs 0; clk_AD then shows period 4, 2 low / 2 high, starting low.
- **Square wave.** 16 samples of 200 then 16 of 50, repeating, measure_en=1 → first valid: period=32, amp_pp=150, lock=0. Second valid: period=32, lock=1.
- **Hysteresis.** Samples alternating 130/126 around MID=128, HYST=8 → no crossings, no valid. no_carrier=1 one cycle after sample 1023.
- **Lock loss.** Period stream 32, 32, 40 → lock 0→1, then 0 on the third valid. amp_pp is unchanged for a constant-amplitude signal.
- **Loopback sine.** Drive the 32-entry generator table at one sample per strobe → period=32 each valid; amp_pp = table max − min; lock=1 from the second valid.
- **Abort.** Deassert measure_en mid-window, reassert 10 strobes later → no valid during the gap; lock=0; the first valid after re-entry has lock=0 and a correct period.
